seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/seq_alu_mul.sv | 62 ++++++
 rtl/seq_alu.sv | 217 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode enumeration and shared helpers for the combinational
//               ALU and the sequential seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_OP_W = 5;

    typedef enum logic [c_OP_W-1:0] {
        PASSTHROUGH     = 5'd0,
        ADD             = 5'd1,
        ADD_WITH_CIN    = 5'd2,
        SUBTRACT        = 5'd3,
        SUB_WITH_CIN    = 5'd4,
        TWOS_COMPLEMENT = 5'd5,
        INCREMENT       = 5'd6,
        DECREMENT       = 5'd7,
        AND             = 5'd8,
        OR              = 5'd9,
        XOR             = 5'd10,
        NOT             = 5'd11,
        ASR             = 5'd12,
        LSR             = 5'd13,
        SHIFT_LEFT      = 5'd14,
        ROTATE_LEFT     = 5'd15,
        MUL             = 5'd16,
        SHL_N           = 5'd17,
        LSR_N           = 5'd18,
        ASR_N           = 5'd19
    } alu_op_t;

    // Ops whose result comes straight off the shared adder; c_out is its carry.
    function automatic logic uses_adder(input alu_op_t op);
        return (op == ADD) || (op == ADD_WITH_CIN) || (op == SUBTRACT) ||
               (op == SUB_WITH_CIN) || (op == TWOS_COMPLEMENT) ||
               (op == INCREMENT) || (op == DECREMENT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_mul
// Description : Iterative shift-add unsigned multiplier, one step per cycle.
//               The final step is presented combinationally while done is high.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic                 r_busy;
    logic [c_CNT_W-1:0]   r_iter;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH:0]       w_upper;

    // Upper half accumulates the multiplicand; lower half holds remaining multiplier bits.
    always_comb begin
        w_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0]) begin
            w_upper = w_upper + {1'b0, r_mcand};
        end
    end

    assign product = {w_upper, r_acc[WIDTH-1:1]};
    assign done    = r_busy && (r_iter == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_iter  <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_iter  <= '0;
            r_mcand <= mcand;
            r_acc   <= {{WIDTH{1'b0}}, mplier};
        end else if (r_busy) begin
            if (done) begin
                r_busy <= 1'b0;
            end else begin
                r_acc  <= product;
                r_iter <= r_iter + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Valid/ready sequential ALU with registered result and flags.
//               Define SEQ_ALU_MUL_EN to build the iterative MUL path.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             c_in,
    input  alu_op_t          op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             f_zero,
    output logic             f_negative,
    output logic             f_overflow,
    output logic             f_parity
);

    localparam int             c_SH_W   = $clog2(WIDTH);
    localparam int             c_MSB    = WIDTH - 1;
    localparam logic [WIDTH-1:0] c_MIN_S = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_MAX_S = {1'b0, {(WIDTH-1){1'b1}}};

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [0:0] c_ST_MUL_BUSY = 1'b1;
`endif

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_accept;
    logic             w_load_alu;

    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH:0]   w_sum;
    logic [c_SH_W-1:0] w_shamt;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;

    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    logic             w_load;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c;
    logic             w_fin_ovf;

`ifdef SEQ_ALU_MUL_EN
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
`endif

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_add_a   = in_A;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (op)
            ADD:             begin w_add_b = in_B;  w_add_cin = 1'b0; end
            ADD_WITH_CIN:    begin w_add_b = in_B;  w_add_cin = c_in; end
            SUBTRACT:        begin w_add_b = ~in_B; w_add_cin = 1'b1; end
            SUB_WITH_CIN:    begin w_add_b = ~in_B; w_add_cin = c_in; end
            TWOS_COMPLEMENT: begin w_add_a = '0; w_add_b = ~in_A; w_add_cin = 1'b1; end
            INCREMENT:       begin w_add_b = '0;    w_add_cin = 1'b1; end
            DECREMENT:       begin w_add_b = '1;    w_add_cin = 1'b0; end
            default:         begin w_add_b = '0;    w_add_cin = 1'b0; end
        endcase
    end

    assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_shamt = in_B[c_SH_W-1:0];

    // One guard bit beyond the word catches the last bit shifted off.
    assign w_shl = {1'b0, in_A} << w_shamt;
    assign w_lsr = {in_A, 1'b0} >> w_shamt;
    assign w_asr = $unsigned($signed({in_A, 1'b0}) >>> w_shamt);

    always_comb begin
        w_res   = in_A;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (uses_adder(op)) begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
        end
        case (op)
            ADD, ADD_WITH_CIN:
                w_ovf = (in_A[c_MSB] == in_B[c_MSB]) && (w_sum[c_MSB] != in_A[c_MSB]);
            SUBTRACT, SUB_WITH_CIN:
                w_ovf = (in_A[c_MSB] != in_B[c_MSB]) && (w_sum[c_MSB] != in_A[c_MSB]);
            TWOS_COMPLEMENT, DECREMENT:
                w_ovf = (in_A == c_MIN_S);
            INCREMENT:
                w_ovf = (in_A == c_MAX_S);
            AND:         w_res = in_A & in_B;
            OR:          w_res = in_A | in_B;
            XOR:         w_res = in_A ^ in_B;
            NOT:         w_res = ~in_A;
            ASR:         begin w_res = {in_A[c_MSB], in_A[c_MSB:1]}; w_carry = in_A[0]; end
            LSR:         begin w_res = {1'b0, in_A[c_MSB:1]};        w_carry = in_A[0]; end
            SHIFT_LEFT:  begin w_res = {in_A[c_MSB-1:0], 1'b0};        w_carry = in_A[c_MSB]; end
            ROTATE_LEFT: begin w_res = {in_A[c_MSB-1:0], in_A[c_MSB]}; w_carry = in_A[c_MSB]; end
            SHL_N:       begin w_res = w_shl[WIDTH-1:0]; w_carry = w_shl[WIDTH]; end
            LSR_N:       begin w_res = w_lsr[WIDTH:1];   w_carry = w_lsr[0]; end
            ASR_N:       begin w_res = w_asr[WIDTH:1];   w_carry = w_asr[0]; end
            default:     w_ovf = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
`ifdef SEQ_ALU_MUL_EN
        case (r_state)
            c_ST_IDLE:     if (w_mul_start) w_state_nxt = c_ST_MUL_BUSY;
            c_ST_MUL_BUSY: if (w_mul_done)  w_state_nxt = c_ST_IDLE;
            default:       w_state_nxt = c_ST_IDLE;
        endcase
`endif
    end

    always_comb begin
        in_ready   = (r_state == c_ST_IDLE) && (!out_valid || out_ready);
        w_accept   = in_valid && in_ready;
`ifdef SEQ_ALU_MUL_EN
        w_mul_start = w_accept && (op == MUL);
        w_load_alu  = w_accept && (op != MUL);
`else
        w_load_alu  = w_accept;
`endif
    end

`ifdef SEQ_ALU_MUL_EN
    seq_alu_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .mcand   (in_A),
        .mplier  (in_B),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );
`endif

    // ------------------------------------------------------------------
    // Result register: ALU results and MUL completions are never coincident
    // ------------------------------------------------------------------
    always_comb begin
        w_load    = w_load_alu;
        w_fin_res = w_res;
        w_fin_c   = w_carry;
        w_fin_ovf = w_ovf;
`ifdef SEQ_ALU_MUL_EN
        if (w_mul_done) begin
            w_load    = 1'b1;
            w_fin_res = w_mul_prod[WIDTH-1:0];
            w_fin_c   = |w_mul_prod[2*WIDTH-1:WIDTH];
            w_fin_ovf = |w_mul_prod[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out        <= '0;
            c_out      <= 1'b0;
            out_valid  <= 1'b0;
            f_zero     <= 1'b0;
            f_negative <= 1'b0;
            f_overflow <= 1'b0;
            f_parity   <= 1'b0;
        end else if (w_load) begin
            out        <= w_fin_res;
            c_out      <= w_fin_c;
            out_valid  <= 1'b1;
            f_zero     <= (w_fin_res == '0);
            f_negative <= w_fin_res[c_MSB];
            f_overflow <= w_fin_ovf;
            f_parity   <= ^w_fin_res;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking bench for seq_alu at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_A;
    logic [W-1:0] in_B;
    logic         c_in;
    alu_op_t      op;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         c_out;
    logic         out_valid;
    logic         out_ready;
    logic         f_zero;
    logic         f_negative;
    logic         f_overflow;
    logic         f_parity;

    int n_checks = 0;
    int n_errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_A       (in_A),
        .in_B       (in_B),
        .c_in       (c_in),
        .op         (op),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out        (out),
        .c_out      (c_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f_zero     (f_zero),
        .f_negative (f_negative),
        .f_overflow (f_overflow),
        .f_parity   (f_parity)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        op       = o;
        in_A     = a;
        in_B     = b;
        c_in     = ci;
        in_valid = 1'b1;
        check_eq("ready_at_issue", in_ready, 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] r, input logic c,
                             input logic ov);
        check_eq({tag, ".valid"}, out_valid, 1);
        check_eq({tag, ".out"}, out, r);
        check_eq({tag, ".c_out"}, c_out, c);
        check_eq({tag, ".ovf"}, f_overflow, ov);
        check_eq({tag, ".zero"}, f_zero, (r == 0));
        check_eq({tag, ".neg"}, f_negative, r[W-1]);
        check_eq({tag, ".par"}, f_parity, ^r);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_A      = '0;
        in_B      = '0;
        c_in      = 1'b0;
        op        = PASSTHROUGH;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", out_valid, 0);
        check_eq("rst.out", out, 0);
        check_eq("rst.flags", {c_out, f_zero, f_negative, f_overflow, f_parity}, 0);
        rst_n = 1'b1;
        tick;
        check_eq("rst.ready_after", in_ready, 1);

        // ADD with signed overflow, then hold while out_ready is low
        issue(ADD, 8'h7F, 8'h01, 1'b0);
        check_res("add_ovf", 8'h80, 1'b0, 1'b1);
        check_eq("add_ovf.ready_blocked", in_ready, 0);
        tick;
        check_res("add_hold", 8'h80, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick;
        check_eq("add_consumed", out_valid, 0);

        issue(SUBTRACT, 8'h00, 8'h01, 1'b0);
        check_res("sub_borrow", 8'hFF, 1'b0, 1'b0);
        issue(SUBTRACT, 8'h80, 8'h01, 1'b0);
        check_res("sub_ovf", 8'h7F, 1'b1, 1'b1);
        issue(ADD, 8'hFF, 8'h01, 1'b0);
        check_res("add_carry", 8'h00, 1'b1, 1'b0);
        issue(ASR_N, 8'h80, 8'h03, 1'b0);
        check_res("asr_n", 8'hF0, 1'b0, 1'b0);
        issue(LSR_N, 8'h81, 8'h01, 1'b0);
        check_res("lsr_n", 8'h40, 1'b1, 1'b0);
        issue(SHL_N, 8'h81, 8'h00, 1'b0);
        check_res("shl_n0", 8'h81, 1'b0, 1'b0);
        issue(alu_op_t'(5'b10100), 8'h5A, 8'h33, 1'b1);
        check_res("op20_pass", 8'h5A, 1'b0, 1'b0);

        // Back-to-back INCREMENT, one result per cycle
        op       = INCREMENT;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_A = W'(i * 3);
            tick;
            check_eq("inc_b2b.out", out, W'(i * 3 + 1));
            check_eq("inc_b2b.ready", in_ready, 1);
        end
        in_A = 8'h10;
        tick;
        check_res("inc_last", 8'h11, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_A      = 8'h20;
        #1;
        check_eq("inc_stall.ready", in_ready, 0);
        tick;
        check_res("inc_stall_hold", 8'h11, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check_eq("inc_stall_drain", out_valid, 0);

`ifdef SEQ_ALU_MUL_EN
        issue(MUL, 8'h10, 8'h10, 1'b0);
        check_eq("mul.ready_0", in_ready, 0);
        check_eq("mul.valid_0", out_valid, 0);
        for (int k = 1; k < 8; k++) begin
            tick;
            check_eq("mul.busy_ready", in_ready, 0);
            check_eq("mul.busy_valid", out_valid, 0);
        end
        tick;
        check_res("mul_hi", 8'h00, 1'b1, 1'b1);

        issue(MUL, 8'h0D, 8'h0B, 1'b0);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            if (out_valid) seen = 1;
            else tick;
        end
        check_eq("mul2.timeout", seen, 1);
        check_res("mul2", 8'h8F, 1'b0, 1'b0);
        tick;

        // Reset pulse in the middle of a MUL
        issue(MUL, 8'h03, 8'h05, 1'b0);
        tick;
        tick;
        rst_n = 1'b0;
        #1;
`else
        issue(MUL, 8'h10, 8'h10, 1'b0);
        check_res("mul_pass", 8'h10, 1'b0, 1'b0);
        out_ready = 1'b0;
        issue(ADD, 8'h01, 8'h01, 1'b0);
        rst_n = 1'b0;
        #1;
`endif
        check_eq("midrst.valid", out_valid, 0);
        check_eq("midrst.ready", in_ready, 1);
        check_eq("midrst.out", out, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (out_valid) seen++;
        end
        check_eq("midrst.no_result", seen, 0);
        issue(ADD, 8'h02, 8'h03, 1'b0);
        check_res("post_rst_add", 8'h05, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
